// File: rtl/regem_pipe.sv
// -----------------------------------------------------------------------------
// regem_pipe
//
// EX/MEM pipeline register with a valid/ready handshake and a two-entry skid
// buffer. The main entry drives the memory-stage outputs; the skid entry holds
// one extra beat so the memory stage can stall without a combinational ready
// path back into execute. All state advances on the falling edge of clk.
//
// Parameters
//   DATA_W     width of ALUResult / WriteData
//   WA_W       width of the destination register address
//   GATE_CTRL  1: control outputs forced to 0 while out_valid=0
//              0: control outputs always show the main entry
//
// Ports
//   clk, rst_n                    clock (falling-edge active), async active-low reset
//   flush                         drop every held and incoming beat at this edge
//   in_valid / in_ready           execute-side handshake
//   PCSrcEA..WA3E                 execute-stage beat (control + data)
//   out_valid / out_ready         memory-side handshake
//   PCSrcM..WA3M                  memory-stage beat (control + data)
//   occupancy                     number of held entries, 0..2
// -----------------------------------------------------------------------------
module regem_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WA_W      = 4,
    parameter bit          GATE_CTRL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              PCSrcEA,
    input  logic              RegWriteEA,
    input  logic              MemWriteEA,
    input  logic              MemtoRegE,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [WA_W-1:0]   WA3E,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              PCSrcM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              MemtoRegM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [WA_W-1:0]   WA3M,

    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              pcsrc;
        logic              regwrite;
        logic              memwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [WA_W-1:0]   wa3;
    } beat_t;

    beat_t in_beat;
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  accept;
    logic  consume;
    logic  ctrl_en;

    assign in_beat = '{
        pcsrc:      PCSrcEA,
        regwrite:   RegWriteEA,
        memwrite:   MemWriteEA,
        memtoreg:   MemtoRegE,
        alu_result: ALUResultE,
        write_data: WriteDataE,
        wa3:        WA3E
    };

    // in_ready comes straight from a flop, so out_ready never reaches execute
    // combinationally; the skid entry absorbs the one beat in flight.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign consume  = main_valid_q & out_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the if/else tree can leave one unassigned and infer a latch.
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // Flush overrides consume and accept; data fields are left stale.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            // Skid is never occupied while main is empty.
            if (accept) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end
        end else if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_beat;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid = main_valid_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // A bubble must never write memory, the register file or the PC.
    assign ctrl_en   = GATE_CTRL ? main_valid_q : 1'b1;

    assign PCSrcM     = main_q.pcsrc    & ctrl_en;
    assign RegWriteM  = main_q.regwrite & ctrl_en;
    assign MemWriteM  = main_q.memwrite & ctrl_en;
    assign MemtoRegM  = main_q.memtoreg & ctrl_en;
    assign ALUResultM = main_q.alu_result;
    assign WriteDataM = main_q.write_data;
    assign WA3M       = main_q.wa3;

endmodule

// File: tb/tb_regem_pipe.sv
// -----------------------------------------------------------------------------
// tb_regem_pipe
//
// Drives two regem_pipe instances from one stimulus stream:
//   dut_a  DATA_W=64, WA_W=5, GATE_CTRL=1
//   dut_b  DATA_W=32, WA_W=4, GATE_CTRL=0 (sees the low bits of every beat)
// A queue model holds the beats that must be in flight; a compare process
// checks both instances against it on every rising edge, between the falling
// edges where state moves. Directed sequences with literal expectations run
// first, then randomized traffic with occasional flushes.
// -----------------------------------------------------------------------------
module tb_regem_pipe;

    typedef struct packed {
        logic        pcs;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic [63:0] alu;
        logic [63:0] wd;
        logic [4:0]  wa;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  flush = 1'b0;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b0;
    beat_t drv = '0;

    logic        in_ready_a, out_valid_a, pcs_a, rw_a, mw_a, m2r_a;
    logic [63:0] alu_a, wd_a;
    logic [4:0]  wa_a;
    logic [1:0]  occ_a;

    logic        in_ready_b, out_valid_b, pcs_b, rw_b, mw_b, m2r_b;
    logic [31:0] alu_b, wd_b;
    logic [3:0]  wa_b;
    logic [1:0]  occ_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regem_pipe #(.DATA_W(64), .WA_W(5), .GATE_CTRL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .PCSrcEA(drv.pcs), .RegWriteEA(drv.rw), .MemWriteEA(drv.mw), .MemtoRegE(drv.m2r),
        .ALUResultE(drv.alu), .WriteDataE(drv.wd), .WA3E(drv.wa),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .PCSrcM(pcs_a), .RegWriteM(rw_a), .MemWriteM(mw_a), .MemtoRegM(m2r_a),
        .ALUResultM(alu_a), .WriteDataM(wd_a), .WA3M(wa_a),
        .occupancy(occ_a)
    );

    regem_pipe #(.DATA_W(32), .WA_W(4), .GATE_CTRL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .PCSrcEA(drv.pcs), .RegWriteEA(drv.rw), .MemWriteEA(drv.mw), .MemtoRegE(drv.m2r),
        .ALUResultE(drv.alu[31:0]), .WriteDataE(drv.wd[31:0]), .WA3E(drv.wa[3:0]),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .PCSrcM(pcs_b), .RegWriteM(rw_b), .MemWriteM(mw_b), .MemtoRegM(m2r_b),
        .ALUResultM(alu_b), .WriteDataM(wd_b), .WA3M(wa_b),
        .occupancy(occ_b)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t trunc(input beat_t b);
        beat_t r = b;
        r.alu[63:32] = '0;
        r.wd[63:32]  = '0;
        r.wa[4]      = 1'b0;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    beat_t q[$];
    beat_t last_main   = '0;   // what the main entry holds when nothing is valid
    bit    last_known  = 1'b1; // false after a flush: stale contents unspecified

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last_main  = '0;
            last_known = 1'b1;
        end else if (flush) begin
            q.delete();
            last_known = 1'b0;
        end else begin
            bit acc, con;
            acc = in_valid && (q.size() < 2);
            con = (q.size() > 0) && out_ready;
            if (con) void'(q.pop_front());
            if (acc) q.push_back(drv);
            if (q.size() > 0) begin
                last_main  = q[0];
                last_known = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        int    n;
        beat_t pa, pb;
        n  = q.size();
        pa = {pcs_a, rw_a, mw_a, m2r_a, alu_a, wd_a, wa_a};
        pb = {pcs_b, rw_b, mw_b, m2r_b, 32'b0, alu_b, 32'b0, wd_b, 1'b0, wa_b};
        check("status_a", {out_valid_a, occ_a, in_ready_a}, {n != 0, 2'(n), n < 2});
        check("status_b", {out_valid_b, occ_b, in_ready_b}, {n != 0, 2'(n), n < 2});
        if (n != 0) begin
            check("beat_a", pa, q[0]);
            check("beat_b", pb, trunc(q[0]));
        end else begin
            check("bubble_ctrl_a", {pcs_a, rw_a, mw_a, m2r_a}, 4'b0000);
            if (last_known) begin
                check("stale_data_a", {alu_a, wd_a, wa_a}, {last_main.alu, last_main.wd, last_main.wa});
                check("stale_beat_b", pb, trunc(last_main));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [63:0] alu, input logic [3:0] ctrl,
                          input logic [4:0] wa);
        in_valid = v;
        drv      = {ctrl, alu, ~alu, wa};
    endtask

    initial begin
        // Reset with a live beat at the inputs: nothing may be captured.
        set_in(1'b1, 64'hDEAD_BEEF, 4'b1111, 5'd7);
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid_a, 1'b0);
        check("rst_occ", occ_a, 2'd0);
        check("rst_ready", in_ready_a, 1'b1);
        check("rst_outs_a", {pcs_a, rw_a, mw_a, m2r_a, alu_a, wd_a, wa_a}, '0);
        check("rst_outs_b", {pcs_b, rw_b, mw_b, m2r_b, alu_b, wd_b, wa_b}, '0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_no_beat", out_valid_a, 1'b0);

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 64'(k), 4'b0100, 5'd5);
            tick();
            check("stream_alu", alu_a, 64'(k));
            check("stream_occ_ready", {occ_a, in_ready_a, rw_a, wa_a}, {2'd1, 1'b1, 1'b1, 5'd5});
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", occ_a, 2'd0);

        // Back-pressure fills the skid; draining restores in_ready.
        out_ready = 1'b0;
        set_in(1'b1, 64'h10, 4'b0100, 5'd1);
        tick();
        set_in(1'b1, 64'h20, 4'b1110, 5'd2);
        tick();
        check("bp_full", {occ_a, in_ready_a}, {2'd2, 1'b0});
        check("bp_hold_alu", alu_a, 64'h10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_second", {alu_a, occ_a, in_ready_a}, {64'h20, 2'd1, 1'b1});
        tick();
        check("bubble_gated_a", {out_valid_a, pcs_a, rw_a, mw_a}, 4'b0000);
        check("bubble_ungated_b", {out_valid_b, pcs_b, rw_b, mw_b, alu_b}, {1'b0, 3'b111, 32'h20});

        // Flush with both entries full and a beat arriving.
        out_ready = 1'b0;
        set_in(1'b1, 64'h30, 4'b0010, 5'd3);
        tick();
        set_in(1'b1, 64'h40, 4'b0010, 5'd4);
        tick();
        check("pre_flush_occ", occ_a, 2'd2);
        set_in(1'b1, 64'h50, 4'b0010, 5'd6);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty", {out_valid_a, occ_a, mw_a, in_ready_a}, {1'b0, 2'd0, 1'b0, 1'b1});
        in_valid = 1'b0;
        tick();
        check("flush_no_ghost", out_valid_a, 1'b0);

        // Full-width beat on the 64-bit instance, truncated on the 32-bit one.
        set_in(1'b1, 64'hFFFF_0000_1234_5678, 4'b0000, 5'd31);
        tick();
        check("wide_a", {alu_a, wa_a}, {64'hFFFF_0000_1234_5678, 5'd31});
        check("narrow_b", {alu_b, wa_b}, {32'h1234_5678, 4'd15});

        // Asynchronous reset mid-operation clears both entries at once.
        out_ready = 1'b0;
        set_in(1'b1, 64'h60, 4'b1111, 5'd9);
        tick();
        check("pre_arst_occ", occ_a, 2'd2);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_immediate", {out_valid_a, occ_a, in_ready_a, mw_a}, {1'b0, 2'd0, 1'b1, 1'b0});
        #1 rst_n = 1'b1;
        tick();

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            drv.pcs   = 1'($urandom);
            drv.rw    = 1'($urandom);
            drv.mw    = 1'($urandom);
            drv.m2r   = 1'($urandom);
            drv.alu   = {$urandom, $urandom};
            drv.wd    = {$urandom, $urandom};
            drv.wa    = 5'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
